// File: rtl/shift_sequencer_reg.sv
// Datapath register with parallel load/hold and a multi-step sequenced
// operation (shift/rotate/arith-shift/inc/dec/clear), one step per clock.
module shift_sequencer_reg #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din,
  input  logic               load,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               sin,
  output logic [WIDTH-1:0]   dout,
  output logic               sout,
  output logic               busy,
  output logic               done,
  output logic               zero
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_ROL = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_SRA = 3'd4;
  localparam logic [2:0] OP_INC = 3'd5;
  localparam logic [2:0] OP_DEC = 3'd6;

  logic [0:0]         state, state_n;
  logic [SHAMT_W-1:0] count, count_n;
  logic [2:0]         op_q, op_n;
  logic [WIDTH-1:0]   dout_n;
  logic               sout_n;
  logic               busy_n;
  logic               done_n;
  logic [WIDTH-1:0]   step_val;
  logic               step_out;
  logic [WIDTH:0]     inc_sum;

  // One step of the latched operation applied to the current contents.
  always_comb begin
    step_val = dout;
    step_out = sout;
    inc_sum  = {1'b0, dout} + (WIDTH+1)'(1);
    case (op_q)
      OP_SLL: begin
        step_val = {dout[WIDTH-2:0], sin};
        step_out = dout[WIDTH-1];
      end
      OP_SRL: begin
        step_val = {sin, dout[WIDTH-1:1]};
        step_out = dout[0];
      end
      OP_ROL: begin
        step_val = {dout[WIDTH-2:0], dout[WIDTH-1]};
        step_out = dout[WIDTH-1];
      end
      OP_ROR: begin
        step_val = {dout[0], dout[WIDTH-1:1]};
        step_out = dout[0];
      end
      OP_SRA: begin
        step_val = {dout[WIDTH-1], dout[WIDTH-1:1]};
        step_out = dout[0];
      end
      OP_INC: begin
        step_val = inc_sum[WIDTH-1:0];
        step_out = inc_sum[WIDTH];
      end
      OP_DEC: begin
        step_val = dout - WIDTH'(1);
        step_out = (dout == '0);
      end
      default: begin
        step_val = '0;
        step_out = 1'b0;
      end
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n = state;
    count_n = count;
    op_n    = op_q;
    dout_n  = dout;
    sout_n  = sout;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          dout_n = din;
        end else if (start) begin
          if (shamt == '0) begin
            done_n = 1'b1;
          end else begin
            op_n    = op;
            count_n = shamt;
            state_n = SHIFT;
          end
        end
      end
      default: begin
        if (load) begin
          dout_n  = din;
          count_n = '0;
          state_n = IDLE;
        end else begin
          dout_n  = step_val;
          sout_n  = step_out;
          count_n = count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
    endcase
    busy_n = (state_n == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      op_q  <= OP_SLL;
      dout  <= '0;
      sout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      op_q  <= op_n;
      dout  <= dout_n;
      sout  <= sout_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  assign zero = (dout == '0);

endmodule

// File: tb/tb_shift_sequencer_reg.sv
// Scoreboard bench for shift_sequencer_reg: the driver pushes the expected
// final contents per sequence, a monitor pops and compares on each done pulse.
module tb_shift_sequencer_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  din;
  logic          load;
  logic          start;
  logic [2:0]    op;
  logic [SW-1:0] shamt;
  logic          sin;
  logic [W-1:0]  dout;
  logic          sout;
  logic          busy;
  logic          done;
  logic          zero;

  shift_sequencer_reg #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .reset(reset), .din(din), .load(load), .start(start),
    .op(op), .shamt(shamt), .sin(sin), .dout(dout), .sout(sout),
    .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] sb[$];   // {dout, sout} expected at each done pulse
  logic [7:0] exp_dout;
  logic       exp_sout;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Result of n whole steps of an operation, from closed-form arithmetic.
  function automatic void model(input logic [2:0] o, input logic [7:0] v, input int n,
                                input logic s_in, input logic s_prev,
                                output logic [7:0] r, output logic s);
    int x, vi, fill;
    vi   = int'(v);
    fill = (1 << n) - 1;
    if (n == 0) begin
      r = v;
      s = s_prev;
      return;
    end
    case (o)
      3'd0: begin x = (vi << n) | (s_in ? fill : 0);             s = v[8-n]; end
      3'd1: begin x = (vi >> n) | (s_in ? (fill << (8-n)) : 0);  s = v[n-1]; end
      3'd2: begin x = (vi << n) | (vi >> (8-n));                  s = v[8-n]; end
      3'd3: begin x = (vi >> n) | (vi << (8-n));                  s = v[n-1]; end
      3'd4: begin x = (vi >> n) | (v[7] ? (fill << (8-n)) : 0);  s = v[n-1]; end
      3'd5: begin x = vi + n; s = (((vi + n - 1) & 255) == 255);  end
      3'd6: begin x = vi - n; s = (((vi - n + 1) & 255) == 0);    end
      default: begin x = 0; s = 1'b0; end
    endcase
    r = 8'(x & 255);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_unexpected: got done=1 expected no pending sequence at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk8("done_dout", dout, e[8:1]);
        chk1("done_sout", sout, e[0]);
        chk1("done_zero", zero, (e[8:1] == 8'h00));
        chk1("done_busy", busy, 1'b0);
      end
    end
  end

  task automatic run_seq(input logic do_load, input logic [7:0] v, input logic [2:0] o,
                         input int n, input logic s);
    logic [7:0] r, mid, base;
    logic so, mso;
    int busy_cnt;
    bit got;
    if (do_load) begin
      load = 1'b1; din = v;
      @(negedge clk);
      load = 1'b0;
      chk8("load_dout", dout, v);
      chk1("load_sout_hold", sout, exp_sout);
      exp_dout = v;
    end
    start = 1'b1; op = o; shamt = SW'(n); sin = s;
    base = exp_dout;
    model(o, base, n, s, exp_sout, r, so);
    sb.push_back({r, so});
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); shamt = SW'($urandom);
    busy_cnt = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (done === 1'b1) begin
        got = 1;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        model(o, base, c, s, exp_sout, mid, mso);
        chk8("step_dout", dout, mid);
        @(negedge clk);
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done within 20 cycles expected done after %0d steps", n);
    end else begin
      chk8("busy_cycles", 8'(busy_cnt), 8'(n));
    end
    exp_dout = r;
    exp_sout = so;
  endtask

  initial begin
    logic [7:0] r;
    logic so;
    reset = 1'b0; load = 1'b1; din = 8'hA5; start = 1'b1;
    op = 3'd0; shamt = '0; sin = 1'b0;
    @(negedge clk);
    chk8("rst_dout", dout, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_zero", zero, 1'b1);
    chk1("rst_sout", sout, 1'b0);
    exp_dout = 8'h00; exp_sout = 1'b0;

    reset = 1'b1; start = 1'b0; load = 1'b1; din = 8'hA5;
    @(negedge clk);
    load = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk8("hold_dout", dout, 8'hA5);
      chk1("hold_zero", zero, 1'b0);
      chk1("hold_sout", sout, 1'b0);
    end
    exp_dout = 8'hA5;

    run_seq(1'b1, 8'h81, 3'd2, 3, 1'b0);
    run_seq(1'b1, 8'h80, 3'd4, 7, 1'b0);
    run_seq(1'b0, 8'h00, 3'd4, 0, 1'b0);
    run_seq(1'b1, 8'hFF, 3'd5, 1, 1'b0);
    chk1("inc_wrap_zero", zero, 1'b1);
    run_seq(1'b0, 8'h00, 3'd6, 1, 1'b0);
    run_seq(1'b1, 8'h5A, 3'd7, 4, 1'b1);

    // Abort: load on the second busy cycle must win and suppress done.
    load = 1'b1; din = 8'h01;
    @(negedge clk);
    load = 1'b0; start = 1'b1; op = 3'd0; shamt = SW'(5); sin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk1("abort_busy1", busy, 1'b1);
    @(negedge clk);
    load = 1'b1; din = 8'h3C;
    @(negedge clk);
    load = 1'b0;
    chk8("abort_dout", dout, 8'h3C);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    model(3'd0, 8'h01, 1, 1'b0, exp_sout, r, so);
    chk1("abort_sout", sout, so);
    @(negedge clk);
    chk1("abort_done2", done, 1'b0);
    exp_dout = 8'h3C; exp_sout = so;

    repeat (40) begin
      run_seq(($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom),
              int'($urandom_range(0, 7)), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk8("sb_drained", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
